// File: rtl/prog_timer_pkg.sv
// Shared encodings for the programmable timer: count modes and control states.
package prog_timer_pkg;

  // Count mode; reserved codes 2'b10/2'b11 fall back to wrap behaviour.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_ONESHOT = 2'b01
  } mode_e;

  // Control state: RUN counts ticks, HALT freezes after a one-shot expiry.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage : prog_timer_pkg

// File: rtl/prog_timer_prescaler.sv
// Prescaler: emits one tick every prescale+1 enabled cycles, holds while
// disabled and restarts from zero on request.
module prog_timer_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] pre_cnt_r;
  logic [PRE_W-1:0] pre_cnt_nx_s;
  logic             hit_s;

  assign hit_s = (pre_cnt_r == prescale);
  assign tick  = enable & hit_s;

  // Next prescaler count: restart wins, then advance or wrap on an enabled cycle.
  always_comb begin
    pre_cnt_nx_s = pre_cnt_r;
    if (restart) begin
      pre_cnt_nx_s = PRE_ZERO;
    end else if (enable) begin
      if (hit_s) begin
        pre_cnt_nx_s = PRE_ZERO;
      end else begin
        pre_cnt_nx_s = pre_cnt_r + PRE_ONE;
      end
    end else begin
      pre_cnt_nx_s = pre_cnt_r;
    end
  end

  // Prescaler count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_r <= PRE_ZERO;
    end else begin
      pre_cnt_r <= pre_cnt_nx_s;
    end
  end

endmodule : prog_timer_prescaler

// File: rtl/prog_timer.sv
// Programmable up/down timer with modulus, prescaler, one-shot halt and a
// saturating count of terminal-count events.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dn_up,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     threshold,
  input  logic [PRE_W-1:0] prescale,
  input  logic             load,
  input  logic [N-1:0]     load_val,
  input  logic             clear,
  output logic [N-1:0]     cntout,
  output logic             timeout,
  output logic             done,
  output logic [M-1:0]     ev_cnt
);

  localparam logic [N-1:0] N_ZERO = {N{1'b0}};
  localparam logic [N-1:0] N_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] N_ALL  = {N{1'b1}};
  localparam logic [M-1:0] M_ZERO = {M{1'b0}};
  localparam logic [M-1:0] M_ONE  = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0] M_ALL  = {M{1'b1}};

  state_e       state_r, state_nx_s;
  logic [N-1:0] cnt_r, cnt_nx_s;
  logic         timeout_r, timeout_nx_s;
  logic         done_r, done_nx_s;
  logic [M-1:0] ev_cnt_r, ev_cnt_nx_s;
  logic [N-1:0] tv_s;
  logic         tick_s;
  logic         pre_en_s;
  logic         restart_s;

  // Terminal value: threshold 0 selects the full 2^N modulus.
  assign tv_s = (threshold == N_ZERO) ? N_ALL : (threshold - N_ONE);

  // The prescaler is frozen in HALT and restarted by clear or load.
  assign pre_en_s  = enable & (state_r == RUN);
  assign restart_s = clear | load;

  prog_timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (pre_en_s),
    .restart  (restart_s),
    .prescale (prescale),
    .tick     (tick_s)
  );

  // Next-state and next-output logic; clear outranks load, load outranks tick.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    timeout_nx_s = 1'b0;
    done_nx_s    = done_r;
    ev_cnt_nx_s  = ev_cnt_r;
    if (clear) begin
      state_nx_s  = RUN;
      cnt_nx_s    = N_ZERO;
      done_nx_s   = 1'b0;
      ev_cnt_nx_s = M_ZERO;
    end else if (load) begin
      state_nx_s = RUN;
      cnt_nx_s   = load_val;
      done_nx_s  = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (tick_s) begin
            if (dn_up) begin
              if (cnt_r >= tv_s) begin
                cnt_nx_s     = N_ZERO;
                timeout_nx_s = 1'b1;
              end else begin
                cnt_nx_s = cnt_r + N_ONE;
              end
            end else begin
              if (cnt_r == N_ZERO) begin
                cnt_nx_s     = tv_s;
                timeout_nx_s = 1'b1;
              end else if (cnt_r > tv_s) begin
                cnt_nx_s = tv_s;
              end else begin
                cnt_nx_s = cnt_r - N_ONE;
              end
            end
            if (timeout_nx_s) begin
              if (ev_cnt_r != M_ALL) begin
                ev_cnt_nx_s = ev_cnt_r + M_ONE;
              end else begin
                ev_cnt_nx_s = ev_cnt_r;
              end
              if (mode == MODE_ONESHOT) begin
                state_nx_s = HALT;
                done_nx_s  = 1'b1;
              end else begin
                state_nx_s = RUN;
              end
            end else begin
              ev_cnt_nx_s = ev_cnt_r;
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        HALT: begin
          cnt_nx_s = cnt_r;
        end
        default: begin
          state_nx_s = RUN;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= RUN;
      cnt_r     <= N_ZERO;
      timeout_r <= 1'b0;
      done_r    <= 1'b0;
      ev_cnt_r  <= M_ZERO;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      timeout_r <= timeout_nx_s;
      done_r    <= done_nx_s;
      ev_cnt_r  <= ev_cnt_nx_s;
    end
  end

  assign cntout  = cnt_r;
  assign timeout = timeout_r;
  assign done    = done_r;
  assign ev_cnt  = ev_cnt_r;

endmodule : prog_timer

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_prog_timer;

  logic       clk = 1'b0;
  logic       reset, enable, dn_up, load, clear;
  logic [1:0] mode;
  logic [3:0] threshold, prescale, load_val;
  logic [3:0] cntout;
  logic       timeout, done;
  logic [7:0] ev_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // behavioural model state
  int  m_cnt = 0, m_pre = 0, m_ev = 0;
  bit  m_to = 1'b0, m_done = 1'b0, m_halt = 1'b0;

  prog_timer #(.N(4), .M(8), .PRE_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dn_up(dn_up), .mode(mode),
    .threshold(threshold), .prescale(prescale), .load(load), .load_val(load_val),
    .clear(clear), .cntout(cntout), .timeout(timeout), .done(done), .ev_cnt(ev_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluate the timer rules on every rising edge.
  always @(posedge clk) begin
    int  tv;
    bit  tk;
    if (reset) begin
      m_cnt = 0; m_pre = 0; m_ev = 0; m_to = 0; m_done = 0; m_halt = 0;
    end else if (clear) begin
      m_cnt = 0; m_pre = 0; m_ev = 0; m_to = 0; m_done = 0; m_halt = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_pre = 0; m_to = 0; m_done = 0; m_halt = 0;
    end else if (m_halt || !enable) begin
      m_to = 0;
    end else begin
      tk    = (m_pre == int'(prescale));
      m_pre = tk ? 0 : (m_pre + 1) % 16;
      m_to  = 0;
      if (tk) begin
        tv = (threshold == 4'd0) ? 15 : int'(threshold) - 1;
        if (dn_up) begin
          if (m_cnt >= tv) begin m_cnt = 0; m_to = 1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = tv; m_to = 1; end
          else if (m_cnt > tv) m_cnt = tv;
          else m_cnt = m_cnt - 1;
        end
        if (m_to) begin
          m_ev = (m_ev < 255) ? m_ev + 1 : 255;
          if (mode == 2'b01) begin m_halt = 1; m_done = 1; end
        end
      end
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_cntout",  int'(cntout),  m_cnt);
      chk("model_timeout", int'(timeout), int'(m_to));
      chk("model_done",    int'(done),    int'(m_done));
      chk("model_ev_cnt",  int'(ev_cnt),  m_ev);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    reset = 0; enable = 0; dn_up = 1; mode = 2'b00; threshold = 4'd12;
    prescale = 4'd0; load = 0; load_val = 4'd0; clear = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    do_reset();
    chk_on = 1'b1;
    chk("reset_cntout", int'(cntout), 0);
    chk("reset_ev_cnt", int'(ev_cnt), 0);
    chk("reset_done",   int'(done),   0);

    // Up count, threshold 12, wrap: 1..11,0,1 with one pulse at 11->0.
    threshold = 4'd12; prescale = 4'd0; dn_up = 1; mode = 2'b00; enable = 1;
    for (int k = 0; k < 13; k++) begin
      step();
      chk("up12_cnt", int'(cntout), (k + 1) % 12);
      chk("up12_to",  int'(timeout), (k == 11) ? 1 : 0);
    end
    chk("up12_ev", int'(ev_cnt), 1);

    // Down from reset: 0 -> 11 with pulse, then 10.
    enable = 0; do_reset();
    dn_up = 0; enable = 1;
    step();
    chk("dn12_cnt0", int'(cntout), 11);
    chk("dn12_to0",  int'(timeout), 1);
    step();
    chk("dn12_cnt1", int'(cntout), 10);
    chk("dn12_to1",  int'(timeout), 0);

    // Full modulus with prescale 2: advance every 3rd cycle.
    enable = 0; do_reset();
    threshold = 4'd0; prescale = 4'd2; dn_up = 1; enable = 1;
    for (int k = 1; k <= 48; k++) begin
      step();
      chk("pre_cnt", int'(cntout), (k / 3) % 16);
    end
    chk("pre_to", int'(timeout), 1);
    chk("pre_ev", int'(ev_cnt), 1);

    // One-shot with threshold 4, then load to resume.
    enable = 0; do_reset();
    threshold = 4'd4; prescale = 4'd0; dn_up = 1; mode = 2'b01; enable = 1;
    repeat (4) step();
    chk("os_cnt", int'(cntout), 0);
    chk("os_to", int'(timeout), 1);
    chk("os_done", int'(done), 1);
    repeat (10) step();
    chk("os_hold_cnt", int'(cntout), 0);
    chk("os_hold_done", int'(done), 1);
    load = 1; load_val = 4'd2;
    step();
    chk("os_load_cnt", int'(cntout), 2);
    chk("os_load_done", int'(done), 0);
    load = 0;
    step();
    chk("os_resume_cnt", int'(cntout), 3);

    // Threshold shrunk below the count.
    mode = 2'b00; enable = 0; load = 1; load_val = 4'd9; threshold = 4'd6;
    step();
    load = 0; dn_up = 0; enable = 1;
    step();
    chk("thr_dn_cnt", int'(cntout), 5);
    chk("thr_dn_to", int'(timeout), 0);
    enable = 0; load = 1; load_val = 4'd9;
    step();
    load = 0; dn_up = 1; enable = 1;
    step();
    chk("thr_up_cnt", int'(cntout), 0);
    chk("thr_up_to", int'(timeout), 1);

    // Reset beats load and clear mid-count.
    threshold = 4'd12; repeat (5) step();
    reset = 1; load = 1; clear = 1; load_val = 4'd7;
    step();
    chk("rst_pri_cnt", int'(cntout), 0);
    chk("rst_pri_to", int'(timeout), 0);
    chk("rst_pri_ev", int'(ev_cnt), 0);
    reset = 0; load = 0; clear = 0;

    // Saturation: threshold 1 pulses every tick; 300 pulses.
    threshold = 4'd1; dn_up = 1; mode = 2'b00; prescale = 4'd0; enable = 1;
    repeat (300) step();
    chk("sat_ev", int'(ev_cnt), 255);
    chk("sat_to", int'(timeout), 1);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      load      = ($urandom_range(0, 29) == 0);
      load_val  = 4'($urandom_range(0, 15));
      enable    = ($urandom_range(0, 9) < 8);
      dn_up     = 1'($urandom_range(0, 1));
      mode      = 2'($urandom_range(0, 3));
      threshold = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) prescale = 4'($urandom_range(0, 3));
      step();
    end

    idle_inputs();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_prog_timer
